// File: rtl/dec_unbinder_scan.sv
// -----------------------------------------------------------------------------
// dec_unbinder_scan
//   Recovers the level of one feature from a bound sparse hypervector.
//   The encoder binds a level by rotating it left by the feature's shift. This
//   block undoes that by rotating right. It then walks the level codebook one
//   entry per cycle and scores each entry as popcount(unbound & level). The
//   index with the highest score is reported, together with that score.
//
// Ports
//   clk             clock, all state on the rising edge
//   nrst            asynchronous active-low reset
//   start_decoding  request, sampled only while idle
//   bound_hv        bound HV, captured with an accepted request
//   shift           feature shift, captured with an accepted request (mod HV_DIM)
//   level_hv        level codebook, must stay stable while busy
//   busy            high whenever the FSM is not idle
//   done            one-cycle pulse, best_level/best_overlap valid
//   best_level      index of the best-matching level
//   best_overlap    overlap score of best_level
//   dbg_state       current FSM state (0=IDLE, 1=SCAN, 2=DONE)
//
// Handshake: start_decoding is a fire-and-forget request. It is taken on any
//   rising edge where the FSM is idle and ignored (not queued) otherwise. The
//   result is signalled by a single-cycle done pulse NUM_LEVELS cycles after
//   the accepting edge. best_level/best_overlap keep the previous result until
//   the final scan edge of the next request.
// -----------------------------------------------------------------------------
module dec_unbinder_scan #(
   parameter int HV_DIM     = 1024,
   parameter int NUM_LEVELS = 10,
   parameter int SW         = $clog2(HV_DIM),
   parameter int LW         = $clog2(NUM_LEVELS),
   parameter int OW         = $clog2(HV_DIM + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start_decoding,
   input  logic [HV_DIM-1:0] bound_hv,
   input  logic [SW-1:0]     shift,
   input  logic [HV_DIM-1:0] level_hv [0:NUM_LEVELS-1],
   output logic              busy,
   output logic              done,
   output logic [LW-1:0]     best_level,
   output logic [OW-1:0]     best_overlap,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [LW-1:0] LAST_IDX = LW'(NUM_LEVELS - 1);

   state_t              state;
   logic [HV_DIM-1:0]   unbound_hv;
   logic [LW-1:0]       idx;
   logic [LW-1:0]       run_best;
   logic [OW-1:0]       run_ovl;

   logic [2*HV_DIM-1:0] rot_dbl;
   logic [HV_DIM-1:0]   rot_hv;
   logic [HV_DIM-1:0]   match_v;
   logic [OW-1:0]       ovl;
   logic                take_new;
   logic [LW-1:0]       nxt_best;
   logic [OW-1:0]       nxt_ovl;

   // Rotate right: shifting a doubled copy right leaves bit j of the low half
   // equal to bound[(j + shift) mod HV_DIM], which is exactly the wrap-around.
   assign rot_dbl = {bound_hv, bound_hv} >> (int'(shift) % HV_DIM);
   assign rot_hv  = rot_dbl[HV_DIM-1:0];

   // Overlap of the captured unbound HV with the codebook entry under scan.
   always_comb begin
      match_v = unbound_hv & level_hv[idx];
      ovl     = '0;
      for (int i = 0; i < HV_DIM; i++) begin
         ovl = ovl + OW'(match_v[i]);
      end
   end

   // Strict compare so that equal scores keep the lower (earlier) index.
   always_comb begin
      take_new = (ovl > run_ovl);
      nxt_best = take_new ? idx : run_best;
      nxt_ovl  = take_new ? ovl : run_ovl;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state        <= IDLE;
         unbound_hv   <= '0;
         idx          <= '0;
         run_best     <= '0;
         run_ovl      <= '0;
         best_level   <= '0;
         best_overlap <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_decoding) begin
                  unbound_hv <= rot_hv;
                  idx        <= '0;
                  run_best   <= '0;
                  run_ovl    <= '0;
                  state      <= SCAN;
               end
            end
            SCAN: begin
               run_best <= nxt_best;
               run_ovl  <= nxt_ovl;
               idx      <= idx + LW'(1);
               // Publish on the edge that scores the last entry, so the
               // final compare is included in the reported result.
               if (idx == LAST_IDX) begin
                  best_level   <= nxt_best;
                  best_overlap <= nxt_ovl;
                  state        <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Decoded straight from the state register, so both fall with reset.
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_dec_unbinder_scan.sv
// -----------------------------------------------------------------------------
// tb_dec_unbinder_scan
//   Directed bench for dec_unbinder_scan with HV_DIM=16, NUM_LEVELS=10.
//   Inputs are driven on the falling edge; outputs are sampled on the falling
//   edge before new inputs are applied.
// -----------------------------------------------------------------------------
module tb_dec_unbinder_scan;

   localparam int HV_DIM     = 16;
   localparam int NUM_LEVELS = 10;
   localparam int SW         = $clog2(HV_DIM);
   localparam int LW         = $clog2(NUM_LEVELS);
   localparam int OW         = $clog2(HV_DIM + 1);

   // clock / reset
   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic              start_decoding = 1'b0;
   logic [HV_DIM-1:0] bound_hv = '0;
   logic [SW-1:0]     shift = '0;
   logic [HV_DIM-1:0] level_hv [0:NUM_LEVELS-1];
   logic              busy;
   logic              done;
   logic [LW-1:0]     best_level;
   logic [OW-1:0]     best_overlap;
   logic [1:0]        dbg_state;

   int errors = 0;
   int checks = 0;

   dec_unbinder_scan #(
      .HV_DIM     (HV_DIM),
      .NUM_LEVELS (NUM_LEVELS)
   ) dut (
      .clk            (clk),
      .nrst           (nrst),
      .start_decoding (start_decoding),
      .bound_hv       (bound_hv),
      .shift          (shift),
      .level_hv       (level_hv),
      .busy           (busy),
      .done           (done),
      .best_level     (best_level),
      .best_overlap   (best_overlap),
      .dbg_state      (dbg_state)
   );

   // comparison with immediate assertion
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic clear_levels();
      for (int i = 0; i < NUM_LEVELS; i++) level_hv[i] = '0;
   endtask

   // Issues one request and waits (bounded) for done. lat = cycles from the
   // accepting edge to the done cycle, or -1 if done never came.
   task automatic run_req(input string tag, input logic [HV_DIM-1:0] b, input logic [SW-1:0] s,
                          input int prev_bl, input int prev_bo, output int lat);
      @(negedge clk);
      start_decoding = 1'b1;
      bound_hv       = b;
      shift          = s;
      @(negedge clk);
      start_decoding = 1'b0;
      lat = -1;
      check({tag, "_busy_at_accept"}, 32'(busy), 32'd1);
      check({tag, "_hold_level_at_accept"}, 32'(best_level), 32'(prev_bl));
      check({tag, "_hold_ovl_at_accept"}, 32'(best_overlap), 32'(prev_bo));
      for (int n = 2; n <= 20; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n - 1;
            break;
         end
      end
   endtask

   // Checks result in the done cycle and that done drops the cycle after.
   task automatic check_result(input string tag, input int lat, input int exp_bl, input int exp_bo);
      check({tag, "_latency"}, 32'(lat), 32'd10);
      check({tag, "_best_level"}, 32'(best_level), 32'(exp_bl));
      check({tag, "_best_overlap"}, 32'(best_overlap), 32'(exp_bo));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_idle_after_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      int done_cnt;

      clear_levels();

      // reset state
      #2;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_best_level", 32'(best_level), 32'd0);
      check("reset_best_overlap", 32'(best_overlap), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);

      // T1 basic: rotr(0x0078,3)=0x000F, matches level 4 on 4 bits
      clear_levels();
      level_hv[4] = 16'h000F;
      run_req("t1", 16'h0078, 4'd3, 0, 0, lat);
      check_result("t1", lat, 4, 4);

      // T2 tie: levels 2 and 7 both score 8, lower index wins
      clear_levels();
      level_hv[2] = 16'h00FF;
      level_hv[7] = 16'h00FF;
      run_req("t2", 16'h00FF, 4'd0, 4, 4, lat);
      check_result("t2", lat, 2, 8);

      // T3 wrap: rotr(0xC000,15)=0x8001
      clear_levels();
      level_hv[0] = 16'h8001;
      run_req("t3", 16'hC000, 4'd15, 2, 8, lat);
      check_result("t3", lat, 0, 2);

      // T4 no match: all-zero codebook gives index 0, score 0, single done
      clear_levels();
      run_req("t4", 16'hFFFF, 4'd5, 0, 2, lat);
      check_result("t4", lat, 0, 0);
      done_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("t4_no_extra_done", 32'(done_cnt), 32'd0);

      // T5 busy: starts in scan cycle 3 and in the DONE cycle are ignored
      clear_levels();
      level_hv[4] = 16'h000F;
      done_cnt = 0;
      @(negedge clk);
      start_decoding = 1'b1;
      bound_hv       = 16'h0078;
      shift          = 4'd3;
      @(negedge clk);                 // after accept edge
      start_decoding = 1'b0;
      @(negedge clk);
      @(negedge clk);                 // next edge is scan edge 3
      start_decoding = 1'b1;
      bound_hv       = 16'hFFFF;
      @(negedge clk);
      start_decoding = 1'b0;
      lat = -1;
      for (int n = 5; n <= 20; n++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            lat = n - 1;
            break;
         end
      end
      check("t5_latency", 32'(lat), 32'd10);
      check("t5_best_level", 32'(best_level), 32'd4);
      check("t5_best_overlap", 32'(best_overlap), 32'd4);
      start_decoding = 1'b1;          // sampled while in DONE
      @(negedge clk);
      check("t5_done_start_ignored", 32'(busy), 32'd0);
      check("t5_done_dropped", 32'(done), 32'd0);
      bound_hv = 16'h0078;            // start held into the first idle cycle
      @(negedge clk);
      start_decoding = 1'b0;
      check("t5_idle_start_accepted", 32'(busy), 32'd1);
      check("t5_state_scan", 32'(dbg_state), 32'd1);
      for (int n = 2; n <= 20; n++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            break;
         end
      end
      check("t5_done_count", 32'(done_cnt), 32'd2);
      check("t5_second_best_level", 32'(best_level), 32'd4);
      check("t5_second_best_overlap", 32'(best_overlap), 32'd4);
      @(negedge clk);

      // T6 reset in scan cycle 5: everything clears at once, no done follows
      @(negedge clk);
      start_decoding = 1'b1;
      bound_hv       = 16'h0078;
      shift          = 4'd3;
      @(negedge clk);
      start_decoding = 1'b0;
      repeat (4) @(negedge clk);
      nrst = 1'b0;
      #1;
      check("t6_busy_async", 32'(busy), 32'd0);
      check("t6_done_async", 32'(done), 32'd0);
      check("t6_level_async", 32'(best_level), 32'd0);
      check("t6_ovl_async", 32'(best_overlap), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      done_cnt = 0;
      repeat (14) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("t6_no_done_after_reset", 32'(done_cnt), 32'd0);
      run_req("t6_fresh", 16'h0078, 4'd3, 0, 0, lat);
      check_result("t6_fresh", lat, 4, 4);

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
